// File: rtl/skid_stage_reg_pkg.sv
// Shared constants and state encoding for the operand skid stage.
// The state encoding doubles as the occupancy count.
package skid_stage_reg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/skid_stage_reg_if.sv
// Handshake bundle for skid_stage_reg: upstream beat in, downstream beat out, occupancy.
// The slave modport is the stage itself; the master modport is its surroundings.
interface skid_stage_reg_if
  import skid_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = 2
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [1:0]                occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/skid_stage_reg.sv
// Two-entry skid buffer latching CHANNELS operand words per beat between regfile and ALU.
// in_ready and out_valid decode registered state only, so no input-to-output paths exist.
module skid_stage_reg
  import skid_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  skid_stage_reg_if.slave   bus
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  state_e          state, state_n;
  logic [DW-1:0]   main_q, skid_q;
  logic            push, pop;
  logic            load_main_in, load_main_skid, load_skid;

  assign bus.in_ready  = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_data  = main_q;
  assign bus.occupancy = state;

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush drops held beats and any concurrent push; data registers are left alone.
      state_n = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            state_n      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_n   = ST_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_n        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= bus.in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_skid_stage_reg.sv
// Self-checking bench for skid_stage_reg: directed scenarios plus a randomized run
// compared against a queue-based model of the beats the stage should hold.
module tb_skid_stage_reg;

  localparam int W  = 32;
  localparam int C  = 2;
  localparam int DW = W * C;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  skid_stage_reg_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  skid_stage_reg #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: beats currently held in arrival order, and the value the main register shows.
  logic [DW-1:0] q[$];
  logic [DW-1:0] main_m;

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  // Advance one clock edge and apply the same edge to the model; returns at edge + 1.
  task automatic tick();
    logic do_pop, do_push;
    @(posedge clk);
    if (rst) begin
      q.delete();
      main_m = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && bus.out_ready;
      do_push = bus.in_valid && (q.size() < 2);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(bus.in_data);
      if (q.size() > 0) main_m = q[0];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b1;
    drive(1'b1, {$urandom, $urandom}, 1'b0);
    tick();
    drive(1'b1, {$urandom, $urandom}, 1'b1);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 64'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
  endtask

  task automatic test_streaming();
    drive(1'b1, 64'h11111111_22222222, 1'b1);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h11111111_22222222) begin
      n_bad++; $display("FAIL stream_beat0 got v=%b d=%h want v=1 d=1111111122222222", bus.out_valid, bus.out_data); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL stream_occ0 got %0d want 1", bus.occupancy); end
    drive(1'b1, 64'h33333333_44444444, 1'b1);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h33333333_44444444) begin
      n_bad++; $display("FAIL stream_beat1 got v=%b d=%h want v=1 d=3333333344444444", bus.out_valid, bus.out_data); end
    n_cmp++; if (bus.occupancy !== 2'd1) begin n_bad++; $display("FAIL stream_occ1 got %0d want 1", bus.occupancy); end
    drive(1'b0, '0, 1'b1);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_drain got occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 64'hAAAA0000_AAAA0001, 1'b0);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_after_a got occ=%0d rdy=%b want occ=1 rdy=1", bus.occupancy, bus.in_ready); end
    drive(1'b1, 64'hBBBB0000_BBBB0001, 1'b0);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_after_b got occ=%0d rdy=%b want occ=2 rdy=0", bus.occupancy, bus.in_ready); end
    drive(1'b1, 64'hCCCC0000_CCCC0001, 1'b0);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2 || bus.out_data !== 64'hAAAA0000_AAAA0001) begin
      n_bad++; $display("FAIL bp_c_refused got occ=%0d d=%h want occ=2 d=aaaa0000aaaa0001", bus.occupancy, bus.out_data); end
    drive(1'b1, 64'hCCCC0000_CCCC0001, 1'b1);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hBBBB0000_BBBB0001) begin
      n_bad++; $display("FAIL bp_emit_b got v=%b d=%h want v=1 d=bbbb0000bbbb0001", bus.out_valid, bus.out_data); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hCCCC0000_CCCC0001) begin
      n_bad++; $display("FAIL bp_emit_c got v=%b d=%h want v=1 d=cccc0000cccc0001", bus.out_valid, bus.out_data); end
    drive(1'b0, '0, 1'b1);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL bp_drain got occ=%0d want 0", bus.occupancy); end
  endtask

  task automatic test_flush();
    drive(1'b1, 64'hD0D0D0D0_D1D1D1D1, 1'b0);
    tick();
    drive(1'b1, 64'hE0E0E0E0_E1E1E1E1, 1'b0);
    tick();
    n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_fill got occ=%0d want 2", bus.occupancy); end
    flush = 1'b1;
    drive(1'b1, 64'hF0F0F0F0_F1F1F1F1, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    n_cmp++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_empty got occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'hD0D0D0D0_D1D1D1D1) begin
      n_bad++; $display("FAIL flush_no_ghost got v=%b d=%h want v=0 d=d0d0d0d0d1d1d1d1", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'h12345678_9ABCDEF0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    flush = 1'b1;
    drive(1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b1);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    n_cmp++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'h0) begin
      n_bad++; $display("FAIL midrst_state got occ=%0d v=%b rdy=%b d=%h want occ=0 v=0 rdy=1 d=0",
                        bus.occupancy, bus.out_valid, bus.in_ready, bus.out_data); end
    drive(1'b1, 64'hCAFEF00D_DEADBEEF, 1'b1);
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hCAFEF00D_DEADBEEF) begin
      n_bad++; $display("FAIL midrst_push got v=%b d=%h want v=1 d=cafef00ddeadbeef", bus.out_valid, bus.out_data); end
    drive(1'b0, '0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
      tick();
      n_cmp++;
      if (bus.occupancy !== 2'(q.size()) || bus.out_valid !== (q.size() != 0) ||
          bus.in_ready !== (q.size() != 2) || bus.out_data !== main_m) begin
        n_bad++;
        if (n_bad - bad_before <= 10)
          $display("FAIL rand_cycle%0d got occ=%0d v=%b rdy=%b d=%h want occ=%0d v=%b rdy=%b d=%h", i,
                   bus.occupancy, bus.out_valid, bus.in_ready, bus.out_data,
                   q.size(), (q.size() != 0), (q.size() != 2), main_m);
      end
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    main_m = '0;
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skid_stage_reg.md
# skid_stage_reg

- Parametrised successor to the two-word operand latch between the register file and the ALU in the multi-cycle datapath.
- Captures CHANNELS operand words of WIDTH bits each as one beat, and adds a valid/ready handshake so the stage can stall.
- A two-entry skid buffer gives full throughput with a registered `in_ready`.
- Adds synchronous reset and flush.

## Interface
Parameters:
- `WIDTH`, 32, bits per channel
- `CHANNELS`, 2, operand words per beat; channel k occupies bits [k*WIDTH +: WIDTH]

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discard all held beats at next edge
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept a beat; depends on state only
- `in_data`  in  CHANNELS*WIDTH  beat payload, channels concatenated
- `out_valid`  out  1  main register holds a beat
- `out_ready`  in  1  downstream accepts the beat
- `out_data`  out  CHANNELS*WIDTH  main register contents
- `occupancy`  out  2  beats held: 0, 1 or 2

## Operation
Events:
- push = `in_valid & in_ready`
- pop = `out_valid & out_ready`

State machine, encoded as `occupancy`:
- EMPTY (0)
- ONE (1): main register valid
- FULL (2): main and skid registers valid

Output decodes:
- `out_valid` = state != EMPTY
- `in_ready` = state != FULL
- `out_data` = main register, always

Transitions (no flush, no reset):
- EMPTY
  - push → ONE, main <= `in_data`
  - otherwise stay
- ONE
  - push & pop → ONE, main <= `in_data`
  - push & !pop → FULL, skid <= `in_data`
  - !push & pop → EMPTY
  - neither → stay
- FULL
  - pop → ONE, main <= skid
  - otherwise stay; push is impossible because `in_ready` = 0

Rules:
- Beats leave in arrival order. No beat is duplicated or lost except by `flush` or `rst`.
- `flush` = 1: state → EMPTY at next edge, overriding any push or pop that cycle. A concurrent push is discarded. Main and skid data registers keep their contents.
- In EMPTY, `out_data` holds the last main value. Downstream must qualify it with `out_valid`.
- Channels are fully independent bit slices. No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset values, one edge after `rst` = 1:
  - state EMPTY, `occupancy` 0
  - `out_valid` 0, `in_ready` 1
  - `out_data` 0, skid register 0
- `rst` overrides `flush` and all handshakes. Reset mid-operation drops every held beat.
- Latency: a push into EMPTY sets `out_valid` = 1 on the next cycle, with `out_data` = that beat.
- Throughput: one beat per cycle while `out_ready` = 1.
- A single-cycle `out_ready` drop with `in_valid` held lands one beat in skid. `in_ready` = 0 on the following cycle.
- `in_ready` and `out_valid` are pure decodes of registered state. There is no combinational path from `out_ready` or `in_valid` to any output.
- Upstream may change `in_data` at any time. Data is sampled only on a push edge.

## Structure
Shared package holds:
- State encodings: `ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2.
- Default `WIDTH` constant (32), shared with the datapath.

Sub-modules:
- None needed. One `always @(posedge clk)` for state/data plus continuous assigns for decodes.
- Slices are generated with a generate loop only if per-channel debug taps are added later.

## Test plan
1. Reset: drive garbage, `rst` = 1 for 2 cycles → `occupancy` 0, `out_valid` 0, `in_ready` 1, `out_data` 0.
2. Streaming, WIDTH=32, CHANNELS=2:
   - Push {0x11111111, 0x22222222} then {0x33333333, 0x44444444} back-to-back with `out_ready` = 1.
   - Required: each beat appears one cycle after its push, in order, `occupancy` never above 1.
3. Backpressure:
   - `out_ready` = 0 while pushing beats A, B, C every cycle.
   - Required: `occupancy` reaches 2 and `in_ready` drops after B, so C is not accepted.
   - Raise `out_ready` → A, B, then C emerge in order, one per cycle.
4. Flush while FULL and `in_valid` = 1 → next cycle `occupancy` 0 and `out_valid` 0; the concurrent beat never appears at the output.
5. Reset mid-operation: FULL plus `rst` and `flush` both 1 → reset values as in scenario 1; the next push into EMPTY appears after 1 cycle.
6. Random valid/ready over 10 000 cycles against a FIFO scoreboard → zero mismatches and `in_ready` = (`occupancy` != 2) every cycle.
